// File: rtl/priority_encoder.sv
// rtl/priority_encoder.sv - registered lowest-set-bit priority encoder with "none" flag
module priority_encoder #(
  parameter int WIDTH = 8,
  parameter int IW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bits,
  output logic [IW-1:0]    index
);

  localparam int            LEVELS    = $clog2(WIDTH);
  localparam int            PW        = IW - 1;
  localparam logic [IW-1:0] NONE_CODE = {1'b1, {PW{1'b0}}};

  logic          anySet;
  logic [PW-1:0] winPos;

  // Binary reduction tree: each node keeps "any set" and the subtree-relative position
  // of its lowest set bit; the lower child wins whenever it has a request.
  always_comb begin : reduceTree
    logic [WIDTH-1:0]    nodeSet;
    logic [WIDTH*PW-1:0] nodePos;
    nodeSet = bits;
    nodePos = '0;
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      for (int j = 0; j < (WIDTH >> (lvl + 1)); j++) begin
        if (nodeSet[2*j +: 1] == 1'b1) begin
          nodePos[j*PW +: PW] = nodePos[(2*j)*PW +: PW];
        end else begin
          nodePos[j*PW +: PW] = nodePos[(2*j+1)*PW +: PW] | (PW'(1) << lvl);
        end
        nodeSet[j +: 1] = nodeSet[2*j +: 1] | nodeSet[(2*j+1) +: 1];
      end
    end
    anySet = nodeSet[0];
    winPos = nodePos[PW-1:0];
  end

  // Output flop: reset forces the none code, otherwise capture this cycle's winner
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      index <= NONE_CODE;
    end else if (anySet) begin
      index <= {1'b0, winPos};
    end else begin
      index <= NONE_CODE;
    end
  end

endmodule

// File: tb/tb_priority_encoder.sv
// tb/tb_priority_encoder.sv - directed and exhaustive checks of priority_encoder at WIDTH 8 and 16
module tb_priority_encoder;

  logic        clk;
  logic        rst_n;
  logic [7:0]  bits8;
  logic [3:0]  index8;
  logic [15:0] bits16;
  logic [4:0]  index16;

  int errors;
  int checks;

  priority_encoder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bits  (bits8),
    .index (index8)
  );

  priority_encoder #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bits  (bits16),
    .index (index16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs, clock once, and settle 1ns past the edge before sampling.
  task automatic step(input logic rst, input logic [7:0] b8, input logic [15:0] b16);
    rst_n  = rst;
    bits8  = b8;
    bits16 = b16;
    @(posedge clk);
    #1;
  endtask

  function automatic int refIdx(input int w, input logic [15:0] v);
    for (int i = 0; i < w; i++) begin
      if (v[i]) return i;
    end
    return (w == 8) ? 8 : 16;
  endfunction

  logic [7:0] multiIn  [4];
  int         multiExp [4];

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bits8  = 8'hFF;
    bits16 = 16'hFFFF;
    #2;

    // Reset held two cycles with all requests set
    for (int c = 0; c < 2; c++) begin
      step(1'b0, 8'hFF, 16'hFFFF);
      check("reset8", 32'(index8), 32'd8);
      check("reset16", 32'(index16), 32'd16);
    end
    step(1'b1, 8'h00, 16'h0000);
    check("release8", 32'(index8), 32'd8);
    check("release16", 32'(index16), 32'd16);

    // Walking one
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 8'(1 << k), 16'(1 << (k + 8)));
      check($sformatf("walk8_%0d", k), 32'(index8), 32'(k));
      check($sformatf("walk16_%0d", k + 8), 32'(index16), 32'(k + 8));
    end

    // Multiple set bits
    multiIn[0] = 8'h07; multiExp[0] = 0;
    multiIn[1] = 8'h30; multiExp[1] = 4;
    multiIn[2] = 8'hC0; multiExp[2] = 6;
    multiIn[3] = 8'hFF; multiExp[3] = 0;
    for (int m = 0; m < 4; m++) begin
      step(1'b1, multiIn[m], 16'h8001);
      check($sformatf("multi8_%0d", m), 32'(index8), 32'(multiExp[m]));
      check("multi16", 32'(index16), 32'd0);
    end

    // Zero after traffic
    step(1'b1, 8'h00, 16'h0000);
    check("zero8", 32'(index8), 32'd8);
    check("zero16", 32'(index16), 32'd16);

    // Reset mid-stream overrides the pending result, then normal latency resumes
    step(1'b0, 8'h10, 16'h0400);
    check("midrst8", 32'(index8), 32'd8);
    check("midrst16", 32'(index16), 32'd16);
    step(1'b1, 8'h10, 16'h0400);
    check("postrst8", 32'(index8), 32'd4);
    check("postrst16", 32'(index16), 32'd10);

    // Exhaustive: every 16-bit value, low byte doubles as the 8-bit sweep
    for (int v = 0; v < 65536; v++) begin
      step(1'b1, 8'(v), 16'(v));
      if (v < 256) check("exh8", 32'(index8), 32'(refIdx(8, 16'(v))));
      check("exh16", 32'(index16), 32'(refIdx(16, 16'(v))));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
